// File: rtl/judge_hp.sv
// judge_hp -- round judge and hit-point keeper for the factorization game.
// A player answer is multiplied, registered and compared with the question one
// cycle later, which gives a player-correct or player-wrong event. A small FSM
// races that event against the opponent's OPP_OK inside a DRAW_WIN-cycle
// window. It also applies the hit-point change and reports win or lose.
// Optional build macro: JUDGE_TRIVIAL_REJECT_EN. When it is defined, any
// answer that uses 0 or 1 as a factor is judged wrong.
module judge_hp #(
    parameter int START_HP = 3,
    parameter int DRAW_WIN = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [3:0]  STATE,
    input  logic [15:0] QUESTION_N,
    input  logic        ANS_VALID,
    input  logic [7:0]  ANS_A,
    input  logic [7:0]  ANS_B,
    input  logic        OPP_OK,
    output logic [1:0]  JUDG,
    output logic        WRONG,
    output logic [1:0]  HP,
    output logic [2:0]  PLAYER_HP,
    output logic [2:0]  ENEMY_HP
);

    // Game controller state codes that the judge reacts to
    localparam logic [3:0] ST_READY = 4'b0010;
    localparam logic [3:0] ST_INPUT = 4'b0100;
    localparam logic [3:0] ST_WRONG = 4'b0111;

    // Judgement codes
    localparam logic [1:0] J_NONE = 2'b00;
    localparam logic [1:0] J_GOOD = 2'b01;
    localparam logic [1:0] J_OUCH = 2'b10;
    localparam logic [1:0] J_DRAW = 2'b11;

    // Game result codes
    localparam logic [1:0] R_RUN  = 2'b00;
    localparam logic [1:0] R_WIN  = 2'b01;
    localparam logic [1:0] R_LOSE = 2'b10;

    localparam logic [2:0] HP_START = 3'(START_HP);
    localparam logic [7:0] WIN_LAST = 8'(DRAW_WIN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_WIN_P,
        S_WIN_O,
        S_HOLD_J,
        S_HOLD_W
    } judge_state_t;

    logic         in_input;
    logic [15:0]  prod_reg;
    logic         ans_seen_reg;
    logic         answer_reject;
    logic         prod_match;
    logic         player_correct;
    logic         player_wrong;

    judge_state_t state_reg, state_next;
    logic [7:0]   win_cnt_reg, win_cnt_next;
    logic [1:0]   judg_reg, judg_next;
    logic         wrong_reg, wrong_next;
    logic [2:0]   player_hp_reg, player_hp_next;
    logic [2:0]   enemy_hp_reg, enemy_hp_next;
    logic [1:0]   hp_flag_reg, hp_flag_next;
    logic [1:0]   verdict;

    assign in_input = (STATE == ST_INPUT);

    // Register the full-width product and note that an answer arrived during INPUT
    always_ff @(posedge CLK) begin
        if (RST) begin
            prod_reg     <= 16'd0;
            ans_seen_reg <= 1'b0;
        end else begin
            if (ANS_VALID) begin
                prod_reg <= 16'(ANS_A) * 16'(ANS_B);
            end
            ans_seen_reg <= ANS_VALID && in_input;
        end
    end

`ifdef JUDGE_TRIVIAL_REJECT_EN
    logic [7:0] factors [2];
    logic [1:0] factor_trivial;
    logic       trivial_reg;

    assign factors[0] = ANS_A;
    assign factors[1] = ANS_B;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_trivial
            assign factor_trivial[gi] = (factors[gi] <= 8'd1);
        end
    endgenerate

    // Remember whether the answer used a 0 or 1 factor, aligned with prod_reg
    always_ff @(posedge CLK) begin
        if (RST) begin
            trivial_reg <= 1'b0;
        end else if (ANS_VALID) begin
            trivial_reg <= |factor_trivial;
        end
    end

    assign answer_reject = trivial_reg;
`else
    assign answer_reject = 1'b0;
`endif

    // The question is stable during INPUT, so comparing against the registered
    // product one cycle later is safe. This produces the PC/PW event pair.
    assign prod_match     = (prod_reg == QUESTION_N);
    assign player_correct = ans_seen_reg && prod_match && !answer_reject;
    assign player_wrong   = ans_seen_reg && !(prod_match && !answer_reject);

    // FSM state, window counter, outputs and hit points
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg     <= S_IDLE;
            win_cnt_reg   <= 8'd0;
            judg_reg      <= J_NONE;
            wrong_reg     <= 1'b0;
            player_hp_reg <= HP_START;
            enemy_hp_reg  <= HP_START;
            hp_flag_reg   <= R_RUN;
        end else begin
            state_reg     <= state_next;
            win_cnt_reg   <= win_cnt_next;
            judg_reg      <= judg_next;
            wrong_reg     <= wrong_next;
            player_hp_reg <= player_hp_next;
            enemy_hp_reg  <= enemy_hp_next;
            hp_flag_reg   <= hp_flag_next;
        end
    end

    // Next-state logic: decide the verdict, then apply its hit-point effect
    always_comb begin
        state_next     = state_reg;
        win_cnt_next   = win_cnt_reg;
        judg_next      = judg_reg;
        wrong_next     = wrong_reg;
        player_hp_next = player_hp_reg;
        enemy_hp_next  = enemy_hp_reg;
        hp_flag_next   = hp_flag_reg;
        verdict        = J_NONE;

        case (state_reg)
            S_IDLE: begin
                if (in_input) begin
                    state_next = S_ARMED;
                end
            end
            S_ARMED: begin
                if (!in_input) begin
                    state_next = S_IDLE;
                end else if (player_correct && OPP_OK) begin
                    verdict = J_DRAW;
                end else if (player_correct) begin
                    state_next   = S_WIN_P;
                    win_cnt_next = 8'd0;
                end else if (OPP_OK) begin
                    state_next   = S_WIN_O;
                    win_cnt_next = 8'd0;
                end else if (player_wrong) begin
                    state_next = S_HOLD_W;
                    wrong_next = 1'b1;
                end
            end
            S_WIN_P: begin
                // A late wrong answer from the player cannot spoil a win
                if (!in_input) begin
                    state_next = S_IDLE;
                end else if (OPP_OK) begin
                    verdict = J_DRAW;
                end else if (win_cnt_reg == WIN_LAST) begin
                    verdict = J_GOOD;
                end else begin
                    win_cnt_next = win_cnt_reg + 8'd1;
                end
            end
            S_WIN_O: begin
                if (!in_input) begin
                    state_next = S_IDLE;
                end else if (player_correct) begin
                    verdict = J_DRAW;
                end else if (win_cnt_reg == WIN_LAST) begin
                    verdict = J_OUCH;
                end else begin
                    win_cnt_next = win_cnt_reg + 8'd1;
                end
            end
            S_HOLD_J: begin
                if (!in_input) begin
                    state_next = S_IDLE;
                    judg_next  = J_NONE;
                end
            end
            S_HOLD_W: begin
                if (STATE == ST_WRONG) begin
                    state_next = S_IDLE;
                    wrong_next = 1'b0;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        if (verdict != J_NONE) begin
            state_next   = S_HOLD_J;
            judg_next    = verdict;
            win_cnt_next = 8'd0;
        end

        // Hit points saturate at zero; the decrement that reaches zero ends the game
        if (verdict == J_GOOD && enemy_hp_reg != 3'd0) begin
            enemy_hp_next = enemy_hp_reg - 3'd1;
            if (enemy_hp_reg == 3'd1) begin
                hp_flag_next = R_WIN;
            end
        end
        if (verdict == J_OUCH && player_hp_reg != 3'd0) begin
            player_hp_next = player_hp_reg - 3'd1;
            if (player_hp_reg == 3'd1) begin
                hp_flag_next = R_LOSE;
            end
        end

        // A finished game is restarted once the controller returns to READY
        if (STATE == ST_READY && hp_flag_reg != R_RUN) begin
            player_hp_next = HP_START;
            enemy_hp_next  = HP_START;
            hp_flag_next   = R_RUN;
        end
    end

    assign JUDG      = judg_reg;
    assign WRONG     = wrong_reg;
    assign HP        = hp_flag_reg;
    assign PLAYER_HP = player_hp_reg;
    assign ENEMY_HP  = enemy_hp_reg;

endmodule

// File: tb/tb_judge_hp.sv
// tb_judge_hp -- randomized self-checking bench for judge_hp.
// Each round is described by its answer and opponent timing. Expected outputs
// are derived from event ordering: first correct event, window length, and
// draw/wrong rules. Hit points are tracked as plain integers.
module tb_judge_hp;

    localparam int START_HP = 3;
    localparam int DRAW_WIN = 4;
    localparam int NONE     = 1000;
    localparam int LEN      = 20;

    logic        CLK = 1'b0;
    logic        RST;
    logic [3:0]  STATE;
    logic [15:0] QUESTION_N;
    logic        ANS_VALID;
    logic [7:0]  ANS_A;
    logic [7:0]  ANS_B;
    logic        OPP_OK;
    logic [1:0]  JUDG;
    logic        WRONG;
    logic [1:0]  HP;
    logic [2:0]  PLAYER_HP;
    logic [2:0]  ENEMY_HP;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_php  = START_HP;
    int exp_ehp  = START_HP;
    int exp_flag = 0;

    always #5 CLK = ~CLK;

    judge_hp #(.START_HP(START_HP), .DRAW_WIN(DRAW_WIN)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .STATE      (STATE),
        .QUESTION_N (QUESTION_N),
        .ANS_VALID  (ANS_VALID),
        .ANS_A      (ANS_A),
        .ANS_B      (ANS_B),
        .OPP_OK     (OPP_OK),
        .JUDG       (JUDG),
        .WRONG      (WRONG),
        .HP         (HP),
        .PLAYER_HP  (PLAYER_HP),
        .ENEMY_HP   (ENEMY_HP)
    );

    task automatic chk(input string tag, input int got, input int expv);
        n_checks++;
        if (got != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, expv);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_all(input string tag, input int ej, input int ew,
                             input int ep, input int ee, input int ef);
        chk({tag, "/JUDG"}, int'(JUDG), ej);
        chk({tag, "/WRONG"}, int'(WRONG), ew);
        chk({tag, "/PLAYER_HP"}, int'(PLAYER_HP), ep);
        chk({tag, "/ENEMY_HP"}, int'(ENEMY_HP), ee);
        chk({tag, "/HP"}, int'(HP), ef);
        chk({tag, "/excl"}, int'((JUDG != 2'b00) && WRONG), 0);
    endtask

    function automatic bit answer_correct(input int a, input int b, input int n);
        bit ok;
        ok = (a * b == n);
`ifdef JUDGE_TRIVIAL_REJECT_EN
        if (a <= 1 || b <= 1) ok = 1'b0;
`endif
        return ok;
    endfunction

    // ans_at / opp_at: cycle (1..) of the pulse, 0 = not sent
    task automatic run_round(input string tag, input int n, input int a, input int b,
                             input int ans_at, input int opp_at);
        int pc_e, pw_e, o_e, first, second, jcode, jedge, wedge;
        int post_p, post_e, post_f, ej, ew, ep, ee, ef;
        pc_e = NONE; pw_e = NONE; o_e = NONE;
        if (ans_at > 0) begin
            if (answer_correct(a, b, n)) pc_e = ans_at + 1;
            else pw_e = ans_at + 1;
        end
        if (opp_at > 0) o_e = opp_at;
        first  = (pc_e < o_e) ? pc_e : o_e;
        second = (pc_e < o_e) ? o_e : pc_e;
        jcode = 0; jedge = NONE; wedge = NONE;
        if (pw_e < first) begin
            wedge = pw_e;
        end else if (first != NONE) begin
            if (second <= first + DRAW_WIN) begin
                jcode = 3; jedge = second;
            end else begin
                jedge = first + DRAW_WIN;
                jcode = (pc_e == first) ? 1 : 2;
            end
        end
        post_p = exp_php; post_e = exp_ehp; post_f = exp_flag;
        if (jcode == 1 && exp_ehp > 0) begin
            post_e = exp_ehp - 1;
            if (post_e == 0) post_f = 1;
        end
        if (jcode == 2 && exp_php > 0) begin
            post_p = exp_php - 1;
            if (post_p == 0) post_f = 2;
        end

        QUESTION_N = 16'(n);
        STATE = 4'b0100;
        ANS_VALID = 1'b0;
        OPP_OK = 1'b0;
        step();
        for (int k = 1; k <= LEN; k++) begin
            ANS_VALID = (k == ans_at);
            ANS_A = 8'(a);
            ANS_B = 8'(b);
            OPP_OK = (k == opp_at);
            step();
            ej = (k >= jedge) ? jcode : 0;
            ew = (k >= wedge) ? 1 : 0;
            ep = (k >= jedge) ? post_p : exp_php;
            ee = (k >= jedge) ? post_e : exp_ehp;
            ef = (k >= jedge) ? post_f : exp_flag;
            check_all(tag, ej, ew, ep, ee, ef);
        end
        ANS_VALID = 1'b0;
        OPP_OK = 1'b0;
        exp_php = post_p; exp_ehp = post_e; exp_flag = post_f;
        $display("round %s: N=%0d ans=%0d*%0d@%0d opp@%0d judg=%0d@%0d wrong@%0d hp p=%0d e=%0d flag=%0d",
                 tag, n, a, b, ans_at, opp_at, jcode, jedge, wedge, exp_php, exp_ehp, exp_flag);

        STATE = (wedge != NONE) ? 4'b0111 : 4'b1000;
        step();
        check_all({tag, "/exit"}, 0, 0, exp_php, exp_ehp, exp_flag);
        if (exp_flag != 0) begin
            STATE = 4'b0010;
            step();
            exp_php = START_HP; exp_ehp = START_HP; exp_flag = 0;
            check_all({tag, "/reload"}, 0, 0, exp_php, exp_ehp, exp_flag);
            STATE = 4'b1000;
        end
    endtask

    initial begin
        int a, b, n, aa, oa;
        RST = 1'b1; STATE = 4'b0000; QUESTION_N = 16'd0;
        ANS_VALID = 1'b0; ANS_A = 8'd0; ANS_B = 8'd0; OPP_OK = 1'b0;
        repeat (3) step();
        check_all("reset", 0, 0, START_HP, START_HP, 0);
        RST = 1'b0;
        step();
        check_all("post_reset", 0, 0, START_HP, START_HP, 0);

        run_round("good", 35, 5, 7, 1, 0);
        run_round("ouch_ignore_pw", 35, 6, 6, 3, 1);
        STATE = 4'b0010;
        step();
        check_all("ready_no_reload", 0, 0, exp_php, exp_ehp, exp_flag);
        run_round("draw", 35, 5, 7, 1, 3);
        run_round("draw_same", 35, 5, 7, 1, 2);
        run_round("wrong", 35, 4, 9, 1, 0);
        run_round("rearm", 35, 7, 5, 1, 0);
        run_round("last_good", 35, 5, 7, 2, 0);
        run_round("trivial", 35, 1, 35, 1, 0);
        run_round("late_opp", 35, 5, 7, 1, 7);

        for (int r = 0; r < 40; r++) begin
            a = $urandom_range(2, 15);
            b = $urandom_range(2, 15);
            n = a * b;
            if ($urandom_range(0, 2) == 0) b = b + 1;
            if ($urandom_range(0, 9) == 0) begin a = 1; b = n; end
            aa = $urandom_range(0, 9);
            oa = $urandom_range(0, 10);
            run_round("rand", n, a, b, aa, oa);
        end

        // Leaving INPUT in the middle of the opponent's window: no verdict
        QUESTION_N = 16'd35;
        STATE = 4'b0100;
        step();
        OPP_OK = 1'b1;
        step();
        OPP_OK = 1'b0;
        step();
        STATE = 4'b1000;
        for (int k = 0; k < DRAW_WIN + 3; k++) begin
            step();
            check_all("abort", 0, 0, exp_php, exp_ehp, exp_flag);
        end
        $display("round abort: window abandoned, hp p=%0d e=%0d", exp_php, exp_ehp);

        // Reset in the middle of the player's window
        STATE = 4'b0100;
        step();
        ANS_VALID = 1'b1; ANS_A = 8'd5; ANS_B = 8'd7;
        step();
        ANS_VALID = 1'b0;
        step();
        step();
        RST = 1'b1;
        step();
        RST = 1'b0;
        exp_php = START_HP; exp_ehp = START_HP; exp_flag = 0;
        check_all("rst_mid", 0, 0, exp_php, exp_ehp, exp_flag);
        for (int k = 0; k < DRAW_WIN + 4; k++) begin
            step();
            check_all("rst_after", 0, 0, exp_php, exp_ehp, exp_flag);
        end
        $display("round reset_mid_window: outputs back to reset values");
        STATE = 4'b1000;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
